dm_param: RTL
=============

# dm_param

Parametrised data memory for the MIPS datapath, the successor to the fixed 4 KiB data memory. Byte-addressable, little-endian storage in four byte lanes with word/half/byte stores and signed/unsigned loads, a registered read port, alignment exceptions, and a request/ready handshake. A post-reset clear state machine zeroes the array one word per cycle, which lets the reset stay asynchronous. Sits in the MEM stage between the ALU address output and the write-back mux.

## Interface
- ADDR_W, 12, byte-address width; capacity 2**ADDR_W bytes, WORDS = 2**(ADDR_W-2); legal range 4..16.
- TRACE, 1, when 1 every committed store prints "@<PC>: *<word addr> <= <resulting word>" in hex.

- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  access request; accepted when Req & Ready.
- WE  in  1  1 = store, 0 = load.
- MemDst  in  3  access mode: 000 w, 001 h, 010 b, 101 hu, 110 bu; 011, 100 and 111 are reserved.
- A  in  ADDR_W  byte address.
- WD  in  32  store data, right-aligned.
- PC  in  32  PC of the requesting instruction; used for trace only.
- Ready  out  1  high in the IDLE state.
- RValid  out  1  one-cycle pulse; RD is valid.
- RD  out  32  registered load result, extended to 32 bits.
- AdEL  out  1  one-cycle pulse for a misaligned or reserved-mode load.
- AdES  out  1  one-cycle pulse for a misaligned or reserved-mode store.

## Operation
- Reset values: state CLEAR, clear pointer 0, Ready 0, RValid 0, RD 0, AdEL 0, AdES 0. Asserting Reset at any time, including mid-clear, restarts the clear from word 0.
- CLEAR state: writes 0 to word[ptr] on all four lanes, then ptr++. When ptr = WORDS-1 the state moves to IDLE. Req is ignored while in CLEAR.
- IDLE state: Ready = 1. The block never leaves IDLE except on reset.
- Alignment rules:
  - w requires A[1:0] = 00.
  - h and hu require A[0] = 0.
  - b and bu are always aligned.
  - A reserved mode is always an error.
- Store: lanes are selected by A[1:0]. w writes all four lanes; h/hu writes WD[15:0] to lanes {A[1],1} and {A[1],0}; b/bu writes WD[7:0] to lane A[1:0]. Unselected lanes keep their value.
- Load: the word at A[ADDR_W-1:2] is read and the selected lane(s) are extracted. w returns the word unchanged; h and b sign-extend; hu and bu zero-extend.
- Error access: no array write, RD holds its previous value, RValid stays 0, and AdEL (load) or AdES (store) pulses.
- Stores never assert RValid.
- Trace word address = {A[ADDR_W-1:2], 2'b00}, zero-extended to 32 bits.

## Timing
- Clear length: exactly WORDS cycles from the first rising edge after Reset deasserts. Ready rises after edge number WORDS, e.g. 1024 cycles for ADDR_W = 12.
- Ready is driven combinationally from the state register.
- Throughput: one access per cycle, with no bubbles.
- Store: the array is updated at the accepting edge.
- Load: RD and RValid are registered at the accepting edge, giving 1-cycle latency. RValid is high only in the cycle after acceptance.
- AdEL/AdES: registered at the accepting edge; high for exactly one cycle.
- Store followed by a load to the same word in the next cycle: the load returns the new data (write-first across cycles).
- A single access cannot both read and write, so there are no same-cycle read/write conflicts.
- Reset asserted mid-access: all outputs clear immediately (asynchronous), and any pending RValid/AdEL/AdES is dropped.

## Test plan
- Reset/clear, ADDR_W = 12: Ready stays 0 for exactly 1024 cycles after release; then lw 0x000 -> 0x00000000 and lw 0xFFC -> 0x00000000. Req pulsed during the clear produces no RValid.
- Extension: sw 0x80000001 at 0x10, then:
  - lb 0x10 -> 0x00000001
  - lb 0x13 -> 0xFFFFFF80
  - lbu 0x13 -> 0x00000080
  - lh 0x12 -> 0xFFFF8000
  - lhu 0x12 -> 0x00008000
  - each with RValid one cycle after acceptance.
- Partial stores: sw 0x11223344 at 0x20, sh 0xABCD at 0x22, sb 0xEE at 0x20 -> lw 0x20 = 0xABCD33EE. With TRACE = 1, the final store prints "@<pc>: *00000020 <= abcd33ee".
- Alignment: lw 0x21 -> AdEL one cycle and no RValid. sh 0x23 -> AdES one cycle and lw 0x20 unchanged. MemDst 011 load -> AdEL.
- Back-to-back: sw 0xDEADBEEF at 0x40 in cycle n, lw 0x40 in cycle n+1 -> RD = 0xDEADBEEF in cycle n+2, with Ready held high throughout.
- Reset mid-operation: store 0x12345678 at 0x8, assert Reset for 1 cycle in the middle of a load -> RValid, RD and Ready drop to 0 immediately; clear reruns for 1024 cycles; lw 0x8 -> 0x00000000.

Source files
------------

// File: rtl/dm_param_if.sv
// Bus between the MEM stage and dm_param: request/ready handshake, load
// result, alignment exceptions and a store-trace side channel.
interface dm_param_if #(
  parameter int ADDR_W = 12
);
  logic              Req;
  logic              WE;
  logic [2:0]        MemDst;
  logic [ADDR_W-1:0] A;
  logic [31:0]       WD;
  logic [31:0]       PC;
  logic              Ready;
  logic              RValid;
  logic [31:0]       RD;
  logic              AdEL;
  logic              AdES;
  // One-cycle pulse per committed store, carrying the values the trace line
  // shows: requesting PC, word-aligned byte address and resulting word.
  logic              TraceValid;
  logic [31:0]       TracePc;
  logic [31:0]       TraceAddr;
  logic [31:0]       TraceWord;

  modport master (
    output Req, WE, MemDst, A, WD, PC,
    input  Ready, RValid, RD, AdEL, AdES,
    input  TraceValid, TracePc, TraceAddr, TraceWord
  );

  modport slave (
    input  Req, WE, MemDst, A, WD, PC,
    output Ready, RValid, RD, AdEL, AdES,
    output TraceValid, TracePc, TraceAddr, TraceWord
  );
endinterface

// File: rtl/dm_param.sv
// dm_param: parametrised byte-addressable little-endian data memory for the
// MEM stage. Four byte lanes, w/h/b stores, signed/unsigned loads with a
// registered read port, alignment exceptions, and a post-reset clear FSM
// that zeroes one word per cycle before the block reports Ready.
module dm_param #(
  parameter int ADDR_W = 12,
  parameter bit TRACE  = 1'b1
) (
  input logic       Clk,
  input logic       Reset,
  dm_param_if.slave bus
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int PTR_W = ADDR_W - 2;

  localparam logic [2:0] MODE_W  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_B  = 3'b010;
  localparam logic [2:0] MODE_HU = 3'b101;
  localparam logic [2:0] MODE_BU = 3'b110;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  nextPtr;

  logic [3:0][7:0]   mem [WORDS];

  logic              accept;
  logic              errAccess;
  logic [PTR_W-1:0]  wordIdx;
  logic [3:0]        byteEn;
  logic [3:0][7:0]   storeData;
  logic [3:0][7:0]   readWord;
  logic [3:0][7:0]   mergedWord;
  logic [31:0]       loadVal;
  logic [15:0]       halfSel;
  logic [7:0]        byteSel;

  logic [3:0]        memWe;
  logic [PTR_W-1:0]  memIdx;
  logic [3:0][7:0]   memData;

  assign bus.Ready = (state == IDLE);
  assign accept    = bus.Req && (state == IDLE);
  assign wordIdx   = bus.A[ADDR_W-1:2];
  assign readWord  = mem[wordIdx];

  // State register and clear pointer; reset restarts the clear from word 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= nextState;
      ptr   <= nextPtr;
    end
  end

  // Clear sweeps every word once, then the block parks in IDLE for good.
  always_comb begin
    nextState = state;
    nextPtr   = ptr;
    if (state == CLEAR) begin
      nextPtr = ptr + PTR_W'(1);
      if (ptr == PTR_W'(WORDS - 1)) begin
        nextState = IDLE;
        nextPtr   = '0;
      end
    end
  end

  // Mode decode: alignment check, lane enables and lane-replicated store data.
  always_comb begin
    errAccess = 1'b0;
    byteEn    = 4'b0000;
    storeData = bus.WD;
    case (bus.MemDst)
      MODE_W: begin
        errAccess = (bus.A[1:0] != 2'b00);
        byteEn    = 4'b1111;
      end
      MODE_H, MODE_HU: begin
        errAccess = bus.A[0];
        byteEn    = bus.A[1] ? 4'b1100 : 4'b0011;
        storeData = {2{bus.WD[15:0]}};
      end
      MODE_B, MODE_BU: begin
        byteEn    = 4'b0001 << bus.A[1:0];
        storeData = {4{bus.WD[7:0]}};
      end
      default: errAccess = 1'b1;
    endcase
  end

  // Load extraction from the addressed word with sign or zero extension.
  always_comb begin
    halfSel = bus.A[1] ? {readWord[3], readWord[2]} : {readWord[1], readWord[0]};
    byteSel = readWord[bus.A[1:0]];
    loadVal = '0;
    case (bus.MemDst)
      MODE_W:  loadVal = readWord;
      MODE_H:  loadVal = {{16{halfSel[15]}}, halfSel};
      MODE_HU: loadVal = {16'h0000, halfSel};
      MODE_B:  loadVal = {{24{byteSel[7]}}, byteSel};
      MODE_BU: loadVal = {24'h000000, byteSel};
      default: loadVal = '0;
    endcase
  end

  // Array write port is shared between the clear sweep and accepted stores.
  always_comb begin
    memWe      = 4'b0000;
    memIdx     = wordIdx;
    memData    = storeData;
    mergedWord = readWord;
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) mergedWord[i] = storeData[i];
    end
    if (state == CLEAR) begin
      memWe   = 4'b1111;
      memIdx  = ptr;
      memData = '0;
    end else if (accept && bus.WE && !errAccess) begin
      memWe   = byteEn;
    end
  end

  // Byte-lane storage; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (memWe[i]) mem[memIdx][i] <= memData[i];
    end
  end

  // Registered load result and one-cycle exception pulses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bus.RValid <= 1'b0;
      bus.RD     <= '0;
      bus.AdEL   <= 1'b0;
      bus.AdES   <= 1'b0;
    end else begin
      bus.RValid <= accept && !bus.WE && !errAccess;
      bus.AdEL   <= accept && !bus.WE && errAccess;
      bus.AdES   <= accept && bus.WE && errAccess;
      if (accept && !bus.WE && !errAccess) bus.RD <= loadVal;
    end
  end

  generate
    if (TRACE) begin : g_trace
      // Capture each committed store so the trace consumer can print it.
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          bus.TraceValid <= 1'b0;
          bus.TracePc    <= '0;
          bus.TraceAddr  <= '0;
          bus.TraceWord  <= '0;
        end else begin
          bus.TraceValid <= accept && bus.WE && !errAccess;
          if (accept && bus.WE && !errAccess) begin
            bus.TracePc   <= bus.PC;
            bus.TraceAddr <= 32'({wordIdx, 2'b00});
            bus.TraceWord <= mergedWord;
          end
        end
      end
    end else begin : g_no_trace
      assign bus.TraceValid = 1'b0;
      assign bus.TracePc    = '0;
      assign bus.TraceAddr  = '0;
      assign bus.TraceWord  = '0;
    end
  endgenerate

endmodule
